// File: rtl/cpu554_pkg.sv
// Shared types for the 554 CPU front end: the pc_mode encoding used by IF's pc
// control and the instruction/PC pair carried from IF to ID.
package cpu554_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_STALL  = 2'b00,
    PC_NORMAL = 2'b01,
    PC_REG    = 2'b10,
    PC_IMM    = 2'b11
  } pc_mode_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_buffer.sv
// IF -> ID decoupling FIFO with valid/ready on both sides, a pc_stall hint for
// IF's pc control, a redirect flush and a saturating stall-cycle counter.
module if_id_buffer
  import cpu554_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [31:0]              if_instr,
  input  logic [31:0]              if_pc,
  output logic                     if_ready,
  output logic                     pc_stall,
  input  logic                     flush,
  output logic                     id_valid,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_pc_plus1,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  if_id_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  if_id_entry_t head;
  logic         push, pop;

  // The extra pointer bit makes the difference equal DEPTH when full, 0 when empty.
  assign occupancy = wr_ptr - rd_ptr;
  assign if_ready  = (occupancy != FULL_CNT);
  assign pc_stall  = ~if_ready;
  assign id_valid  = (occupancy != '0);

  assign push = if_valid & if_ready;
  assign pop  = id_valid & id_ready;

  assign head        = mem[rd_ptr[AW-1:0]];
  assign id_instr    = id_valid ? head.instr     : NOP_INSTR;
  assign id_pc       = id_valid ? head.pc        : 32'h0;
  assign id_pc_plus1 = id_valid ? head.pc + 32'h1 : 32'h0;

  // NOTE: storage has no reset; stale entries are masked by id_valid and a reset
  // port here would only cost a reset tree on every data bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{instr: if_instr, pc: if_pc};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Counts every cycle IF is held off, including the cycle a redirect arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (if_valid && !if_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: stimulus pushes expected deliveries into a
// scoreboard queue, a negedge monitor pops and compares on each ID handshake.
module tb_if_id_buffer;
  import cpu554_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic [31:0] if_instr, if_pc;
  logic        if_ready, pc_stall, id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus1;
  logic [1:0]  occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int model_occ  = 0;
  if_id_entry_t sb_q[$];

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .pc_stall(pc_stall), .flush(flush), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1), .id_ready(id_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, update the expected model, then step past the edge.
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl = 1'b0, input logic r = 1'b0);
    bit acc, take;
    if_valid = v; if_instr = instr; if_pc = pc; id_ready = rdy; flush = fl; rst = r;
    acc  = v && (model_occ != DEPTH);
    take = rdy && (model_occ != 0);
    if (r || fl) begin
      model_occ = 0;
      sb_q.delete();
    end else begin
      if (acc) sb_q.push_back('{instr: instr, pc: pc});
      model_occ = model_occ + int'(acc) - int'(take);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " id_valid"},    32'(id_valid), 32'd0);
    check({tag, " id_instr"},    id_instr, 32'h0000_0000);
    check({tag, " id_pc"},       id_pc, 32'd0);
    check({tag, " id_pc_plus1"}, id_pc_plus1, 32'd0);
    check({tag, " occupancy"},   32'(occupancy), 32'd0);
    check({tag, " if_ready"},    32'(if_ready), 32'd1);
    check({tag, " pc_stall"},    32'(pc_stall), 32'd0);
    check({tag, " stall_cnt"},   32'(stall_cnt), 32'd0);
  endtask

  // Monitor: every ID handshake that the DUT will honour must match the queue head.
  always @(negedge clk) begin
    if (rst === 1'b0 && flush === 1'b0 && id_valid && id_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_delivery: got pc %h expected nothing", id_pc);
      end else begin
        if_id_entry_t e;
        e = sb_q.pop_front();
        check("deliver instr", id_instr, e.instr);
        check("deliver pc", id_pc, e.pc);
        check("deliver pc_plus1", id_pc_plus1, e.pc + 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_valid = 1'b1; if_instr = 32'h1234_5678; if_pc = 32'd0;
    id_ready = 1'b0; flush = 1'b0;

    // Reset held two cycles with IF pushing.
    drive(1, 32'h1234_5678, 32'd3, 0, 0, 1);
    drive(1, 32'h1234_5678, 32'd3, 0, 0, 1);
    check_reset_state("reset");

    // Single pass.
    drive(1, 32'hDEAD_0001, 32'd5, 0);
    check("single id_valid", 32'(id_valid), 32'd1);
    check("single id_instr", id_instr, 32'hDEAD_0001);
    check("single id_pc", id_pc, 32'd5);
    check("single id_pc_plus1", id_pc_plus1, 32'd6);
    check("single occupancy", 32'(occupancy), 32'd1);
    drive(0, 32'h0, 32'h0, 1);
    check("single drained id_valid", 32'(id_valid), 32'd0);
    check("single drained id_instr", id_instr, 32'h0000_0000);

    // Fill and stall.
    drive(1, 32'hA000_0000, 32'd0, 0);
    drive(1, 32'hA000_0001, 32'd1, 0);
    check("fill occupancy", 32'(occupancy), 32'd2);
    check("fill pc_stall", 32'(pc_stall), 32'd1);
    check("fill if_ready", 32'(if_ready), 32'd0);
    check("fill stall_cnt", 32'(stall_cnt), 32'd0);
    drive(1, 32'hA000_0002, 32'd2, 0);
    check("blocked occupancy", 32'(occupancy), 32'd2);
    check("blocked stall_cnt", 32'(stall_cnt), 32'd1);
    drive(0, 32'h0, 32'h0, 1);
    check("pop-from-full if_ready", 32'(if_ready), 32'd1);
    drive(0, 32'h0, 32'h0, 1);
    check("drained occupancy", 32'(occupancy), 32'd0);
    drive(0, 32'h0, 32'h0, 1); // id_ready while empty must not underflow
    check("underflow occupancy", 32'(occupancy), 32'd0);

    // Streaming across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'hB000_0000 + 32'(i), 32'(i), 1);
      check($sformatf("stream%0d occupancy", i), 32'(occupancy), 32'd1);
      check($sformatf("stream%0d pc_stall", i), 32'(pc_stall), 32'd0);
    end
    drive(0, 32'h0, 32'h0, 1);
    check("stream stall_cnt", 32'(stall_cnt), 32'd1);

    // Flush while full, with a concurrent push and pop.
    drive(1, 32'hC000_000A, 32'd10, 0);
    drive(1, 32'hC000_000B, 32'd11, 0);
    check("preflush occupancy", 32'(occupancy), 32'd2);
    drive(1, 32'hC000_0009, 32'd9, 1, 1);
    check("flush occupancy", 32'(occupancy), 32'd0);
    check("flush id_valid", 32'(id_valid), 32'd0);
    check("flush if_ready", 32'(if_ready), 32'd1);
    check("flush stall_cnt", 32'(stall_cnt), 32'd2);
    drive(0, 32'h0, 32'h0, 1);
    drive(0, 32'h0, 32'h0, 1);
    check("postflush id_valid", 32'(id_valid), 32'd0);

    // Reset mid-stream while full and stalled.
    drive(1, 32'hD000_0000, 32'd20, 0);
    drive(1, 32'hD000_0001, 32'd21, 0);
    drive(1, 32'hD000_0002, 32'd22, 0);
    check("prereset stall_cnt", 32'(stall_cnt), 32'd3);
    check("prereset occupancy", 32'(occupancy), 32'd2);
    drive(1, 32'hD000_0003, 32'd23, 0, 0, 1);
    check_reset_state("midreset");
    drive(0, 32'h0, 32'h0, 1);
    check("postreset id_valid", 32'(id_valid), 32'd0);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
